// File: rtl/ppg_pkg.sv
// Purpose: shared types for the PPG sample demux (LED phase, FSM state, phase decode).
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package ppg_pkg;

    // LED phase as seen on the LED_RED/LED_IR pair; encoding is {ir, red}
    typedef enum logic [1:0] {
        PH_NONE = 2'b00,
        PH_RED  = 2'b01,
        PH_IR   = 2'b10,
        PH_BOTH = 2'b11
    } phase_e;

    // demux controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_EMIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    // widest settle counter needed for SETTLE_CYC up to 255
    localparam int SETTLE_W = 8;

    // map the two LED enables onto a phase
    function automatic phase_e decode_phase(input logic led_red, input logic led_ir);
        phase_e ph;
        case ({led_ir, led_red})
            2'b01:   ph = PH_RED;
            2'b10:   ph = PH_IR;
            2'b11:   ph = PH_BOTH;
            default: ph = PH_NONE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/ppg_accumulator.sv
// Purpose: sums 2^AVG_LOG2 ADC samples and flags the sample that completes the window.
// Latency: sum visible one cycle after each add; done is combinational with the final add.
// Backpressure: none; clr has priority over add and discards any partial sum.
module ppg_accumulator #(
    parameter int ADC_W    = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      add,
    input  logic [ADC_W-1:0]          din,
    output logic [ADC_W+AVG_LOG2-1:0] acc,
    output logic                      done
);
    import ppg_pkg::*;

    localparam int ACC_W = ADC_W + AVG_LOG2;
    // one extra bit so the count still fits when AVG_LOG2 is 0
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next sum/count: clear wins, otherwise add zero-extended sample
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add) begin
            acc_d = acc_q + ACC_W'(din);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // sum and sample-count registers
    always_ff @(posedge CLK) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc  = acc_q;
    // the add that brings the count to 2^AVG_LOG2 completes the window
    assign done = add && !clr && (cnt_q == LAST_CNT);

endmodule

// File: rtl/ppg_sample_demux.sv
// Purpose: demux ADC samples into averaged RED/IR values, blanking LED settle time; optional PPG_CLIP_DETECT_EN adds a clip flag.
// Latency: with continuous ADC_Valid, strobe fires SETTLE_CYC + 2^AVG_LOG2 + 1 cycles after the phase starts.
// Backpressure: none; ADC_Valid outside the accumulate window is dropped, strobes are unconditional.
module ppg_sample_demux #(
    parameter int ADC_W      = 8,
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 2
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             en,
    input  logic [ADC_W-1:0] ADC,
    input  logic             ADC_Valid,
    input  logic             LED_RED,
    input  logic             LED_IR,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic             RED_Valid,
    output logic             IR_Valid,
    output logic             Phase_Err,
    output logic             Clip
);
    import ppg_pkg::*;

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

    state_e                state_q, state_d;
    phase_e                phase_q;
    phase_e                phase_d;
    phase_e                lat_q, lat_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  phase_chg;

    logic                  acc_clr;
    logic                  acc_add;
    logic                  acc_done;
    logic [ACC_W-1:0]      acc;
    logic [ADC_W-1:0]      avg;
    logic                  red_vld;
    logic                  ir_vld;
    logic [ADC_W-1:0]      red_q;
    logic [ADC_W-1:0]      ir_q;

    assign phase_d   = decode_phase(LED_RED, LED_IR);
    assign phase_chg = (phase_d != phase_q);
    // truncating divide by the window length
    assign avg       = ADC_W'(acc >> AVG_LOG2);

    ppg_accumulator #(
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .CLK  (CLK),
        .rst  (rst),
        .clr  (acc_clr),
        .add  (acc_add),
        .din  (ADC),
        .acc  (acc),
        .done (acc_done)
    );

    // phase tracker: last cycle's decoded phase, used for change detection and Phase_Err
    always_ff @(posedge CLK) begin
        if (rst) begin
            phase_q <= PH_NONE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // state register together with the latched window phase and settle countdown
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lat_q    <= PH_NONE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            settle_q <= settle_d;
        end
    end

    // next state: en low or BOTH abort everything; a phase change in any active state
    // either restarts the settle window (RED/IR) or drops back to IDLE (NONE)
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        settle_d = settle_q;
        if (!en || phase_d == PH_BOTH) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (phase_d == PH_RED || phase_d == PH_IR) begin
                        state_d  = ST_SETTLE;
                        lat_d    = phase_d;
                        settle_d = SETTLE_LOAD;
                    end
                end
                ST_SETTLE, ST_ACCUM, ST_EMIT, ST_HOLD: begin
                    if (phase_chg) begin
                        if (phase_d == PH_NONE) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d  = ST_SETTLE;
                            lat_d    = phase_d;
                            settle_d = SETTLE_LOAD;
                        end
                    end else begin
                        case (state_q)
                            ST_SETTLE: begin
                                if (settle_q == '0) begin
                                    state_d = ST_ACCUM;
                                end else begin
                                    settle_d = settle_q - SETTLE_W'(1);
                                end
                            end
                            ST_ACCUM: begin
                                if (acc_done) begin
                                    state_d = ST_EMIT;
                                end
                            end
                            ST_EMIT:  state_d = ST_HOLD;
                            default:  state_d = state_q;
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // outputs: accumulator control, EMIT strobes and the value bypass so the new
    // average is on the bus in the same cycle as its strobe
    always_comb begin
        acc_clr       = (state_q != ST_ACCUM);
        acc_add       = (state_q == ST_ACCUM) && en && ADC_Valid && !phase_chg;
        red_vld       = (state_q == ST_EMIT) && (lat_q == PH_RED);
        ir_vld        = (state_q == ST_EMIT) && (lat_q == PH_IR);
        RED_Valid     = red_vld;
        IR_Valid      = ir_vld;
        RED_ADC_Value = red_vld ? avg : red_q;
        IR_ADC_Value  = ir_vld  ? avg : ir_q;
        Phase_Err     = (phase_q == PH_BOTH);
    end

    // per-channel value registers, written only during EMIT
    always_ff @(posedge CLK) begin
        if (rst) begin
            red_q <= '0;
            ir_q  <= '0;
        end else begin
            if (red_vld) red_q <= avg;
            if (ir_vld)  ir_q  <= avg;
        end
    end

`ifdef PPG_CLIP_DETECT_EN
    logic clip_q, clip_d;

    // sticky rail-hit flag for the current window; cleared whenever not accumulating
    always_comb begin
        clip_d = clip_q;
        if (acc_clr) begin
            clip_d = 1'b0;
        end
        if (acc_add && (ADC == '0 || ADC == '1)) begin
            clip_d = 1'b1;
        end
    end

    // clip flag register
    always_ff @(posedge CLK) begin
        if (rst) begin
            clip_q <= 1'b0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign Clip = (state_q == ST_EMIT) && clip_q;
`else
    assign Clip = 1'b0;
`endif

endmodule

// File: tb/tb_ppg_sample_demux.sv
// Purpose: directed bench for ppg_sample_demux against a sample-queue model of the demux rules.
// Latency: n/a.
// Backpressure: n/a.
module tb_ppg_sample_demux;

    localparam int ADC_W      = 8;
    localparam int SETTLE_CYC = 4;
    localparam int AVG_LOG2   = 2;
    localparam int NS         = 1 << AVG_LOG2;

    logic             CLK = 1'b0;
    logic             rst;
    logic             en;
    logic [ADC_W-1:0] ADC;
    logic             ADC_Valid;
    logic             LED_RED;
    logic             LED_IR;
    logic [ADC_W-1:0] RED_ADC_Value;
    logic [ADC_W-1:0] IR_ADC_Value;
    logic             RED_Valid;
    logic             IR_Valid;
    logic             Phase_Err;
    logic             Clip;

    always #5 CLK = ~CLK;

    ppg_sample_demux #(
        .ADC_W      (ADC_W),
        .SETTLE_CYC (SETTLE_CYC),
        .AVG_LOG2   (AVG_LOG2)
    ) dut (
        .CLK           (CLK),
        .rst           (rst),
        .en            (en),
        .ADC           (ADC),
        .ADC_Valid     (ADC_Valid),
        .LED_RED       (LED_RED),
        .LED_IR        (LED_IR),
        .RED_ADC_Value (RED_ADC_Value),
        .IR_ADC_Value  (IR_ADC_Value),
        .RED_Valid     (RED_Valid),
        .IR_Valid      (IR_Valid),
        .Phase_Err     (Phase_Err),
        .Clip          (Clip)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: mode 0 = idle, 1 = window open (blanking then collecting), 2 = emitting, 3 = waiting
    int m_mode, m_win, m_blank, m_prev, m_red, m_ir;
    int m_samp[$];

    // observations for the hand-computed checks
    int cyc, red_cnt, ir_cnt, red_at, ir_at, perr_cnt, clip_cnt, clip_at, start;

    function automatic int dec(input logic r, input logic i);
        return (i ? 2 : 0) + (r ? 1 : 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic open_win(input int ph);
        m_mode  = 1;
        m_win   = ph;
        m_blank = SETTLE_CYC;
        m_samp.delete();
    endtask

    task automatic clr_obs();
        red_cnt = 0; ir_cnt = 0; red_at = -1; ir_at = -1;
        perr_cnt = 0; clip_cnt = 0; clip_at = -1;
    endtask

    // one clock: compare outputs with the model, record observations, advance the model
    task automatic tick();
        int ph, avg, e_rv, e_iv, e_red, e_ir, e_pe, e_clip;
        bit chg, emit_now, clipx;
        @(negedge CLK);
        emit_now = (m_mode == 2);
        avg = 0;
        clipx = 1'b0;
        foreach (m_samp[k]) begin
            avg += m_samp[k];
            if (m_samp[k] == 0 || m_samp[k] == (1 << ADC_W) - 1) clipx = 1'b1;
        end
        avg    = avg / NS;
        e_rv   = (emit_now && m_win == 1) ? 1 : 0;
        e_iv   = (emit_now && m_win == 2) ? 1 : 0;
        e_red  = e_rv ? avg : m_red;
        e_ir   = e_iv ? avg : m_ir;
        e_pe   = (m_prev == 3) ? 1 : 0;
`ifdef PPG_CLIP_DETECT_EN
        e_clip = (emit_now && clipx) ? 1 : 0;
`else
        e_clip = 0;
`endif
        chk("red_valid", RED_Valid, e_rv);
        chk("ir_valid", IR_Valid, e_iv);
        chk("red_value", RED_ADC_Value, e_red);
        chk("ir_value", IR_ADC_Value, e_ir);
        chk("phase_err", Phase_Err, e_pe);
        chk("clip", Clip, e_clip);

        if (RED_Valid) begin red_cnt++; red_at = cyc; end
        if (IR_Valid)  begin ir_cnt++;  ir_at  = cyc; end
        if (Phase_Err) perr_cnt++;
        if (Clip)      begin clip_cnt++; clip_at = cyc; end

        ph  = dec(LED_RED, LED_IR);
        chg = (ph != m_prev);
        if (e_rv != 0) m_red = avg;
        if (e_iv != 0) m_ir  = avg;
        if (rst) begin
            m_mode = 0; m_samp.delete(); m_red = 0; m_ir = 0; ph = 0;
        end else if (!en || ph == 3) begin
            m_mode = 0; m_samp.delete();
        end else if (m_mode == 0) begin
            if (ph == 1 || ph == 2) open_win(ph);
        end else if (chg) begin
            if (ph == 0) begin m_mode = 0; m_samp.delete(); end
            else open_win(ph);
        end else if (m_mode == 2) begin
            m_mode = 3; m_samp.delete();
        end else if (m_mode == 1) begin
            if (m_blank > 0) m_blank--;
            else if (ADC_Valid) begin
                m_samp.push_back(int'(ADC));
                if (m_samp.size() == NS) m_mode = 2;
            end
        end
        m_prev = ph;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_led(input logic r, input logic i);
        LED_RED = r;
        LED_IR  = i;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ADC = '0; ADC_Valid = 1'b0; LED_RED = 1'b0; LED_IR = 1'b0;
        m_mode = 0; m_win = 0; m_blank = 0; m_prev = 0; m_red = 0; m_ir = 0;
        cyc = 0;
        clr_obs();
        @(posedge CLK);
        #1;
        tick();
        chk("rst_red_value", RED_ADC_Value, 0);
        chk("rst_ir_value", IR_ADC_Value, 0);
        chk("rst_valids", {RED_Valid, IR_Valid, Phase_Err, Clip}, 0);

        // 1: steady RED at 100, continuous samples
        rst = 1'b0; en = 1'b1; set_led(1'b1, 1'b0); ADC = 8'd100; ADC_Valid = 1'b1;
        clr_obs(); start = cyc;
        ticks(12);
        chk("t1_latency", red_at - start, 9);
        chk("t1_red_pulses", red_cnt, 1);
        chk("t1_ir_pulses", ir_cnt, 0);
        chk("t1_red_value", RED_ADC_Value, 100);
        chk("t1_model_red", m_red, 100);

        // 2: IR with 10..13 after the settle; blank-time samples are 99 and must be ignored
        set_led(1'b0, 1'b1);
        clr_obs(); start = cyc;
        for (int k = 0; k < 12; k++) begin
            ADC = (k >= 5 && k <= 8) ? 8'(10 + k - 5) : 8'd99;
            tick();
        end
        chk("t2_latency", ir_at - start, 9);
        chk("t2_ir_pulses", ir_cnt, 1);
        chk("t2_ir_value", IR_ADC_Value, 11);
        chk("t2_model_ir", m_ir, 11);
        chk("t2_red_hold", RED_ADC_Value, 100);

        // 3: RED aborted after two samples by a switch to IR
        set_led(1'b1, 1'b0); ADC = 8'd200;
        clr_obs();
        ticks(7);
        set_led(1'b0, 1'b1); ADC = 8'd50; start = cyc;
        ticks(12);
        chk("t3_red_pulses", red_cnt, 0);
        chk("t3_red_hold", RED_ADC_Value, 100);
        chk("t3_ir_latency", ir_at - start, 9);
        chk("t3_ir_value", IR_ADC_Value, 50);

        // 4: BOTH for five cycles mid-accumulation, then release to IR
        set_led(1'b1, 1'b0); ADC = 8'd70;
        ticks(7);
        clr_obs();
        set_led(1'b1, 1'b1);
        ticks(5);
        set_led(1'b0, 1'b1); ADC = 8'd80; start = cyc;
        ticks(12);
        chk("t4_perr_cycles", perr_cnt, 5);
        chk("t4_red_pulses", red_cnt, 0);
        chk("t4_ir_pulses", ir_cnt, 1);
        chk("t4_ir_latency", ir_at - start, 9);
        chk("t4_ir_value", IR_ADC_Value, 80);

        // 5: reset in the middle of a RED accumulation
        set_led(1'b1, 1'b0); ADC = 8'd60;
        ticks(7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_red_value", RED_ADC_Value, 0);
        chk("t5_ir_value", IR_ADC_Value, 0);
        chk("t5_flags", {RED_Valid, IR_Valid, Phase_Err, Clip}, 0);
        clr_obs(); start = cyc;
        ticks(12);
        chk("t5_red_latency", red_at - start, 9);
        chk("t5_red_pulses", red_cnt, 1);
        chk("t5_red_value", RED_ADC_Value, 60);

        // 6a: rail sample in the window -> (255+300)>>2 = 138
        set_led(1'b0, 1'b0);
        ticks(2);
        set_led(1'b1, 1'b0);
        clr_obs(); start = cyc;
        for (int k = 0; k < 12; k++) begin
            ADC = (k == 5) ? 8'd255 : 8'd100;
            tick();
        end
        chk("t6_red_value", RED_ADC_Value, 138);
        chk("t6_red_latency", red_at - start, 9);
`ifdef PPG_CLIP_DETECT_EN
        chk("t6_clip_pulses", clip_cnt, 1);
        chk("t6_clip_align", clip_at, red_at);
`else
        chk("t6_clip_pulses", clip_cnt, 0);
`endif

        // 6b: sparse samples 105,107,109,111 -> 108; zeros presented while ADC_Valid is low
        set_led(1'b0, 1'b0);
        ticks(2);
        set_led(1'b1, 1'b0);
        clr_obs(); start = cyc;
        for (int k = 0; k < 15; k++) begin
            ADC_Valid = k[0];
            ADC = k[0] ? 8'(100 + k) : 8'd0;
            tick();
        end
        ADC_Valid = 1'b1;
        chk("t6b_red_value", RED_ADC_Value, 108);
        chk("t6b_red_latency", red_at - start, 12);
        chk("t6b_clip_pulses", clip_cnt, 0);

        // 7: en low mid-accumulation discards; value register holds
        set_led(1'b0, 1'b0);
        ticks(2);
        set_led(1'b1, 1'b0); ADC = 8'd30;
        clr_obs();
        ticks(7);
        en = 1'b0;
        ticks(2);
        chk("t7_red_hold", RED_ADC_Value, 108);
        en = 1'b1; ADC = 8'd40; start = cyc;
        ticks(12);
        chk("t7_red_pulses", red_cnt, 1);
        chk("t7_red_latency", red_at - start, 9);
        chk("t7_red_value", RED_ADC_Value, 40);

        // 8: switch to IR on the cycle of the final RED sample
        set_led(1'b0, 1'b0);
        ticks(2);
        set_led(1'b1, 1'b0); ADC = 8'd20;
        clr_obs();
        ticks(8);
        set_led(1'b0, 1'b1); ADC = 8'd90; start = cyc;
        ticks(12);
        chk("t8_red_pulses", red_cnt, 0);
        chk("t8_red_hold", RED_ADC_Value, 40);
        chk("t8_ir_latency", ir_at - start, 9);
        chk("t8_ir_value", IR_ADC_Value, 90);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
